sram_pixel_port: RTL and testbench

- SRAM-side responder for the pixel buffer requests issued by the edge-detector datapath.
- Accepts one burst request at a time: either read N pixels from a start address, or write N pixels to it, with N from 0 to 20.
- Sequences one-pixel-per-cycle SRAM accesses.
- Returns read pixels packed in a 20x8 buffer, and pulses done when the burst completes.

---
 rtl/pix_pkg.sv | 22 ++
 rtl/grey_conv.sv | 20 ++
 rtl/sram_pixel_port.sv | 154 +++++++++++++++
 tb/tb_sram_pixel_port.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pix_pkg.sv
// Shared types and sizes for the SRAM pixel port.
//   PIX_W    bits per pixel
//   MAX_PIX  pixels per burst (buffer depth)
//   ADDR_W   SRAM address width
package pix_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned MAX_PIX = 20;
  localparam int unsigned ADDR_W  = 32;

  typedef logic [7:0] pixel_t;
  typedef pixel_t [19:0] pixbuf_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    RESP
  } state_t;

endpackage

// File: rtl/grey_conv.sv
// RGB to greyscale converter: pix_c = (R + 2*G + B) >> 2, 10-bit sum truncated to 8 bits.
// Only present in GREYSCALE_EN builds.
//   rgb    in  24  R=[23:16], G=[15:8], B=[7:0]
//   pix_c  out 8   greyscale pixel (combinational)
`ifdef GREYSCALE_EN
module grey_conv
  import pix_pkg::*;
(
  input  logic [23:0] rgb,
  output pixel_t      pix_c
);

  logic [9:0] sum;

  // Worst case 4*255 = 1020 fits in 10 bits.
  assign sum   = 10'(rgb[23:16]) + 10'({rgb[15:8], 1'b0}) + 10'(rgb[7:0]);
  assign pix_c = sum[9:2];

endmodule
`endif

// File: rtl/sram_pixel_port.sv
// SRAM-side responder for pixel buffer burst requests.
// Accepts one read or write burst of 0..20 pixels, issues one SRAM access per
// cycle, packs read pixels into rdata and pulses done at completion.
// Optional build macro GREYSCALE_EN: read pixels are greyscale of the RGB word,
// otherwise the low byte of sram_rdata is used.
// Ports:
//   clk, rst                    clock, async active-high reset
//   req_valid/req_ready         request handshake (ready == idle)
//   req_write, req_addr,        burst direction, start address,
//   req_count, wdata            pixel count (clamped to 20), write pixels
//   rdata, done                 packed read pixels, completion pulse
//   sram_addr, sram_rd_en,      SRAM address and strobes
//   sram_wr_en, sram_wdata
//   sram_rdata                  SRAM RGB read data, valid the cycle after rd_en
module sram_pixel_port
  import pix_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [4:0]                 req_count,
  input  logic [MAX_PIX*PIX_W-1:0]   wdata,
  output logic [MAX_PIX*PIX_W-1:0]   rdata,
  output logic                       done,
  output logic [ADDR_W-1:0]          sram_addr,
  output logic                       sram_rd_en,
  output logic                       sram_wr_en,
  output logic [PIX_W-1:0]           sram_wdata,
  input  logic [23:0]                sram_rdata
);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [4:0]        cnt;
  logic [4:0]        idx;
  pixbuf_t           wbuf;
  logic              cap_pending;
  logic [4:0]        cap_idx;
  logic [4:0]        cnt_clamp_c;
  pixel_t            pix_c;

  assign cnt_clamp_c = (req_count > 5'(MAX_PIX)) ? 5'(MAX_PIX) : req_count;

  // Pixel extraction from the SRAM word.
`ifdef GREYSCALE_EN
  grey_conv u_grey_conv (
    .rgb   (sram_rdata),
    .pix_c (pix_c)
  );
`else
  logic unused_rgb;
  assign unused_rgb = ^sram_rdata[23:8];
  assign pix_c      = sram_rdata[7:0];
`endif

  // Burst sequencer; idx counts accesses already issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      done        <= 1'b0;
      sram_rd_en  <= 1'b0;
      sram_wr_en  <= 1'b0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      rdata       <= '0;
      base        <= '0;
      cnt         <= '0;
      idx         <= '0;
      wbuf        <= '0;
      cap_pending <= 1'b0;
      cap_idx     <= '0;
    end else begin
      // Read data returns one cycle after the strobe; remember which slot.
      cap_pending <= sram_rd_en;
      cap_idx     <= idx - 5'd1;

      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            base      <= req_addr;
            cnt       <= cnt_clamp_c;
            if (req_write) wbuf <= wdata;
            if (cnt_clamp_c == 5'd0) begin
              state <= RESP;
              done  <= 1'b1;
            end else if (req_write) begin
              state      <= WRITE;
              sram_wr_en <= 1'b1;
              sram_addr  <= req_addr;
              sram_wdata <= wdata[PIX_W-1:0];
              idx        <= 5'd1;
            end else begin
              state      <= READ;
              rdata      <= '0;
              sram_rd_en <= 1'b1;
              sram_addr  <= req_addr;
              idx        <= 5'd1;
            end
          end
        end

        READ: begin
          if (idx == cnt) begin
            state      <= DRAIN;
            sram_rd_en <= 1'b0;
          end else begin
            sram_addr <= base + ADDR_W'(idx);
            idx       <= idx + 5'd1;
          end
        end

        // Last pixel is captured on this edge.
        DRAIN: begin
          state <= RESP;
          done  <= 1'b1;
        end

        WRITE: begin
          if (idx == cnt) begin
            state      <= RESP;
            sram_wr_en <= 1'b0;
            done       <= 1'b1;
          end else begin
            sram_addr  <= base + ADDR_W'(idx);
            sram_wdata <= wbuf[idx];
            idx        <= idx + 5'd1;
          end
        end

        RESP: begin
          state     <= IDLE;
          done      <= 1'b0;
          req_ready <= 1'b1;
        end

        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          done       <= 1'b0;
          sram_rd_en <= 1'b0;
          sram_wr_en <= 1'b0;
        end
      endcase

      if (cap_pending) rdata[cap_idx*PIX_W +: PIX_W] <= pix_c;
    end
  end

endmodule

// File: tb/tb_sram_pixel_port.sv
// Directed self-checking bench for sram_pixel_port.
module tb_sram_pixel_port;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [4:0]   req_count;
  logic [159:0] wdata;
  logic [159:0] rdata;
  logic         done;
  logic [31:0]  sram_addr;
  logic         sram_rd_en;
  logic         sram_wr_en;
  logic [7:0]   sram_wdata;
  logic [23:0]  sram_rdata;

  sram_pixel_port dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_count  (req_count),
    .wdata      (wdata),
    .rdata      (rdata),
    .done       (done),
    .sram_addr  (sram_addr),
    .sram_rd_en (sram_rd_en),
    .sram_wr_en (sram_wr_en),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: word = 0xAA + offset from model_base, or a fixed RGB word.
  logic [31:0] model_base;
  logic        model_fixed;
  initial sram_rdata = '0;
  always @(posedge clk) begin
    if (sram_rd_en)
      sram_rdata <= model_fixed ? 24'h4080C0 : 24'h0000AA + 24'(sram_addr - model_base);
  end

  int n_total;
  int n_pass;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Per-burst observations
  int          n_strobe;
  int          first_s;
  int          last_s;
  int          done_cyc;
  int          n_done;
  int          both_err;
  logic [31:0] ev_addr[$];
  logic [7:0]  ev_wd[$];

  // Issue one request and observe ncyc cycles after the accept edge.
  task automatic run_burst(input logic wr, input logic [31:0] a, input logic [4:0] c,
                           input logic [159:0] wd, input int ncyc);
    @(negedge clk);
    check("ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_count = c;
    wdata     = wd;
    n_strobe = 0; first_s = -1; last_s = -1; done_cyc = -1; n_done = 0; both_err = 0;
    ev_addr.delete();
    ev_wd.delete();
    @(posedge clk);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("busy", req_ready, 1'b0);
        req_valid = 1'b0;
      end
      if (sram_rd_en && sram_wr_en) both_err++;
      if (sram_rd_en || sram_wr_en) begin
        n_strobe++;
        if (first_s < 0) first_s = k;
        last_s = k;
        ev_addr.push_back(sram_addr);
        ev_wd.push_back(sram_wdata);
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = k;
      end
    end
    check("rd_wr_exclusive", both_err, 0);
  endtask

  logic [159:0] exp_rd;
  logic [159:0] wd_ramp;
  int           rst_done;
  int           rst_strobe;

  initial begin
    n_total = 0; n_pass = 0;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_count = '0; wdata = '0;
    model_base = '0; model_fixed = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_rd_en", sram_rd_en, 1'b0);
    check("rst_wr_en", sram_wr_en, 1'b0);
    check("rst_addr", sram_addr, 32'h0);
    check("rst_wdata", sram_wdata, 8'h0);
    check("rst_rdata", rdata, 160'h0);
    rst = 1'b0;

    // Read 4 pixels from 0x100
    model_base = 32'h100;
    run_burst(1'b0, 32'h100, 5'd4, '0, 9);
    check("rd4_strobes", n_strobe, 4);
    check("rd4_first", first_s, 1);
    check("rd4_last", last_s, 4);
    for (int i = 0; i < 4; i++) check("rd4_addr", ev_addr[i], 32'h100 + 32'(i));
    check("rd4_done_cyc", done_cyc, 6);
    check("rd4_done_cnt", n_done, 1);
    exp_rd = '0;
    for (int i = 0; i < 4; i++) exp_rd[i*8 +: 8] = 8'hAA + 8'(i);
    check("rd4_rdata", rdata, exp_rd);
    check("rd4_ready_after", req_ready, 1'b1);

    // Write 20 pixels to 0x200, wdata[i] = i
    for (int i = 0; i < 20; i++) wd_ramp[i*8 +: 8] = 8'(i);
    run_burst(1'b1, 32'h200, 5'd20, wd_ramp, 24);
    check("wr20_strobes", n_strobe, 20);
    check("wr20_first", first_s, 1);
    check("wr20_last", last_s, 20);
    for (int i = 0; i < 20; i++) begin
      check("wr20_addr", ev_addr[i], 32'h200 + 32'(i));
      check("wr20_data", ev_wd[i], 8'(i));
    end
    check("wr20_done_cyc", done_cyc, 21);
    check("wr20_done_cnt", n_done, 1);
    check("wr20_rdata_kept", rdata, exp_rd);

    // Reset during cycle 2 of a 10-pixel read
    model_base = 32'h300;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h300; req_count = 5'd10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_rd_active", sram_rd_en, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_rd_en", sram_rd_en, 1'b0);
    check("abort_ready", req_ready, 1'b1);
    check("abort_rdata", rdata, 160'h0);
    @(negedge clk);
    rst = 1'b0;
    rst_done = 0; rst_strobe = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) rst_done++;
      if (sram_rd_en || sram_wr_en) rst_strobe++;
    end
    check("abort_no_done", rst_done, 0);
    check("abort_no_strobe", rst_strobe, 0);

    // Zero-count read
    run_burst(1'b0, 32'h400, 5'd0, '0, 4);
    check("rd0_strobes", n_strobe, 0);
    check("rd0_done_cyc", done_cyc, 1);
    check("rd0_done_cnt", n_done, 1);
    check("rd0_rdata", rdata, 160'h0);

    // Count 31 clamps to 20
    model_base = 32'h500;
    run_burst(1'b0, 32'h500, 5'd31, '0, 26);
    check("rd31_strobes", n_strobe, 20);
    check("rd31_done_cyc", done_cyc, 22);
    for (int i = 0; i < 20; i++) exp_rd[i*8 +: 8] = 8'hAA + 8'(i);
    check("rd31_rdata", rdata, exp_rd);

    // Address wrap
    model_base = 32'hFFFF_FFFE;
    run_burst(1'b0, 32'hFFFF_FFFE, 5'd3, '0, 8);
    check("wrap_strobes", n_strobe, 3);
    check("wrap_addr0", ev_addr[0], 32'hFFFF_FFFE);
    check("wrap_addr1", ev_addr[1], 32'hFFFF_FFFF);
    check("wrap_addr2", ev_addr[2], 32'h0000_0000);
    check("wrap_done_cyc", done_cyc, 5);
    exp_rd = '0;
    for (int i = 0; i < 3; i++) exp_rd[i*8 +: 8] = 8'hAA + 8'(i);
    check("wrap_rdata", rdata, exp_rd);

    // Pixel extraction from RGB 0x4080C0
    model_fixed = 1'b1;
    run_burst(1'b0, 32'h600, 5'd1, '0, 5);
    exp_rd = '0;
`ifdef GREYSCALE_EN
    exp_rd[7:0] = 8'h80;
`else
    exp_rd[7:0] = 8'hC0;
`endif
    check("pix_rgb", rdata, exp_rd);
    model_fixed = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
